pc_branch_unit: RTL

- Consumer side of the instruction-decode control interface: takes the one-hot branch strobes (b, br, bz, bnz, bcy, bncy, bs, bns, bv, bnv, Call, Ret) plus ALU flag results, and owns the architectural PC.
- Holds the PC register, the condition-flag register (C, Z, S, V) and a hardware return-address stack for Call/Ret.
- Drives the instruction-fetch address each cycle.

---
 rtl/pc_branch_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Owns the architectural PC, the condition-flag register {C,Z,S,V} and a
//   hardware return-address stack. Consumes one-hot branch strobes from
//   decode and produces the next fetch address each advanced cycle.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   en                  advance enable; 0 holds every piece of state
//   b .. bnv, Call, Ret branch strobes from decode
//   offset              signed byte offset for relative branches and Call
//   reg_target          register operand for br
//   alu_c/z/s/v         flag results of the current ALU op
//   flag_we             load the flag register at this edge
//   pc                  registered fetch address
//   pc_plus4            pc + 4 (combinational)
//   taken               last advanced cycle redirected the PC
//   flags               registered {C,Z,S,V}
//   ras_depth           return-stack occupancy (0 .. RAS_DEPTH)
//   ras_ovf, ras_unf    sticky stack overflow / underflow errors
module pc_branch_unit #(
  parameter int              PC_W      = 32,
  parameter int              OFF_W     = 22,
  parameter int              RAS_DEPTH = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           b,
  input  logic                           br,
  input  logic                           bz,
  input  logic                           bnz,
  input  logic                           bcy,
  input  logic                           bncy,
  input  logic                           bs,
  input  logic                           bns,
  input  logic                           bv,
  input  logic                           bnv,
  input  logic                           Call,
  input  logic                           Ret,
  input  logic [OFF_W-1:0]               offset,
  input  logic [PC_W-1:0]                reg_target,
  input  logic                           alu_c,
  input  logic                           alu_z,
  input  logic                           alu_s,
  input  logic                           alu_v,
  input  logic                           flag_we,
  output logic [PC_W-1:0]                pc,
  output logic [PC_W-1:0]                pc_plus4,
  output logic                           taken,
  output logic [3:0]                     flags,
  output logic [$clog2(RAS_DEPTH):0]     ras_depth,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int DEP_W = PTR_W + 1;

  // Word alignment mask: targets always land on a 4-byte boundary.
  localparam logic [PC_W-1:0] ALIGN = ~PC_W'(3);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];

  logic [PC_W-1:0]  rel_target;
  logic [PC_W-1:0]  reg_aligned;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] push_idx;
  logic             ras_full;
  logic             ras_empty;
  logic             cond_hit;
  logic             cond_ok;
  logic [PC_W-1:0]  next_pc;
  logic             redirect;
  logic             do_push;
  logic             do_pop;
  logic             set_ovf;
  logic             set_unf;

  // Flag register layout {C,Z,S,V}.
  logic flag_c, flag_z, flag_s, flag_v;
  assign {flag_c, flag_z, flag_s, flag_v} = flags;

  assign pc_plus4    = pc + PC_W'(4);
  assign rel_target  = (pc + {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset}) & ALIGN;
  assign reg_aligned = reg_target & ALIGN;

  assign ras_full  = (ras_depth == DEP_W'(RAS_DEPTH));
  assign ras_empty = (ras_depth == '0);
  // A full stack has depth RAS_DEPTH whose low PTR_W bits are 0, so the
  // wrapped decrement still points at the last entry.
  assign top_idx   = ras_depth[PTR_W-1:0] - PTR_W'(1);
  assign push_idx  = ras_depth[PTR_W-1:0];

  // Conditional strobes resolve in a fixed order; only the first asserted
  // one is evaluated, so a false winner masks a true lower-priority strobe.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    cond_hit = 1'b1;
    cond_ok  = 1'b0;
    if      (bz)   cond_ok = flag_z;
    else if (bnz)  cond_ok = !flag_z;
    else if (bcy)  cond_ok = flag_c;
    else if (bncy) cond_ok = !flag_c;
    else if (bs)   cond_ok = flag_s;
    else if (bns)  cond_ok = !flag_s;
    else if (bv)   cond_ok = flag_v;
    else if (bnv)  cond_ok = !flag_v;
    else           cond_hit = 1'b0;
  end

  // Strobe priority: Ret > Call > br > b > conditionals.
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (Ret) begin
      if (!ras_empty) begin
        do_pop   = 1'b1;
        next_pc  = ras_mem[top_idx];
        redirect = 1'b1;
      end else begin
        set_unf = 1'b1;
      end
    end else if (Call) begin
      next_pc  = rel_target;
      redirect = 1'b1;
      if (ras_full) set_ovf = 1'b1;
      else          do_push = 1'b1;
    end else if (br) begin
      next_pc  = reg_aligned;
      redirect = 1'b1;
    end else if (b || (cond_hit && cond_ok)) begin
      next_pc  = rel_target;
      redirect = 1'b1;
    end
  end

  // NOTE: stack storage has no reset; its contents are meaningless until
  // pushed, and ras_depth (which is reset) gates every read.
  always_ff @(posedge clk) begin
    if (en && do_push) ras_mem[push_idx] <= pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      pc        <= RESET_PC;
      taken     <= 1'b0;
      flags     <= 4'b0000;
      ras_depth <= '0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else if (en) begin
      pc    <= next_pc;
      taken <= redirect;
      // Branches this cycle already used the old flags above.
      if (flag_we) flags <= {alu_c, alu_z, alu_s, alu_v};
      if (do_push)      ras_depth <= ras_depth + DEP_W'(1);
      else if (do_pop)  ras_depth <= ras_depth - DEP_W'(1);
      if (set_ovf) ras_ovf <= 1'b1;
      if (set_unf) ras_unf <= 1'b1;
    end
  end

endmodule
